// File: rtl/aq_falu_pkg.sv
// Shared types and constants for the FALU EX4 writeback path.
package aq_falu_pkg;

  localparam int FALU_FFLAGS_W = 5;
  localparam int FALU_DATA_W   = 64;
  localparam int FALU_DST_W    = 5;

  typedef struct packed {
    logic [FALU_DATA_W-1:0]   data;
    logic [FALU_FFLAGS_W-1:0] fflags;
    logic [FALU_DST_W-1:0]    dst;
  } falu_wb_entry_t;

  localparam int FALU_WB_ENTRY_W = $bits(falu_wb_entry_t);

endpackage

// File: rtl/aq_falu_wb_fifo.sv
// Generic in-order synchronous FIFO with explicit pointer wrap (DEPTH need not be a power of 2).
module aq_falu_wb_fifo
  import aq_falu_pkg::*;
#(
  parameter int WIDTH = FALU_WB_ENTRY_W,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_wr_en;
  logic w_rd_en;

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // A write into a full FIFO is dropped rather than overwriting the head.
  assign w_wr_en = i_push & ~w_full & ~i_flush;
  assign w_rd_en = i_pop & ~w_empty & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      if (w_rd_en) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage only changes on write or reset, so it can sit behind a gated clock.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/aq_falu_ex4_wb_buf.sv
// FALU fadd EX4 writeback buffer: captures EX3 results, queues them in order and
// presents them to the VPU writeback port; raises the EX4 stall when full.
module aq_falu_ex4_wb_buf
  import aq_falu_pkg::*;
#(
  parameter int DATA_W = FALU_DATA_W,
  parameter int DST_W  = FALU_DST_W,
  parameter int DEPTH  = 2
) (
  input  logic                     forever_cpuclk,
  input  logic                     cpurst,
  input  logic                     fadd_ex3_pipedown,
  input  logic                     fadd_ex3_inst_vld,
  input  logic [DATA_W-1:0]        fadd_ex3_result,
  input  logic [FALU_FFLAGS_W-1:0] fadd_ex3_fflags,
  input  logic [DST_W-1:0]         fadd_ex3_dst,
  input  logic                     vpu_falu_flush,
  input  logic                     vpu_falu_wb_rdy,
  output logic                     falu_vpu_wb_vld,
  output logic [DATA_W-1:0]        falu_vpu_wb_data,
  output logic [FALU_FFLAGS_W-1:0] falu_vpu_wb_fflags,
  output logic [DST_W-1:0]         falu_vpu_wb_dst,
  output logic                     falu_ex4_stall,
  output logic                     falu_ex4_empty
);

  localparam int ENTRY_W = DATA_W + FALU_FFLAGS_W + DST_W;

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;

  // Warm-up pipedowns carry no instruction; flush discards same-cycle traffic.
  assign w_push  = fadd_ex3_pipedown & fadd_ex3_inst_vld & ~vpu_falu_flush;
  assign w_pop   = falu_vpu_wb_vld & vpu_falu_wb_rdy & ~vpu_falu_flush;
  assign w_wdata = {fadd_ex3_result, fadd_ex3_fflags, fadd_ex3_dst};

  aq_falu_wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (forever_cpuclk),
    .i_rst   (cpurst),
    .i_flush (vpu_falu_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign falu_vpu_wb_vld = ~w_empty;
  assign {falu_vpu_wb_data, falu_vpu_wb_fflags, falu_vpu_wb_dst} = w_rdata;

  // Stall depends only on registered occupancy, never on wb_rdy.
  assign falu_ex4_stall = w_full;
  assign falu_ex4_empty = w_empty;

  a_no_push_when_full: assert property (
    @(posedge forever_cpuclk) disable iff (cpurst) !(w_push && w_full)
  );

endmodule

// File: doc/aq_falu_ex4_wb_buf.md
Name: aq_falu_ex4_wb_buf

Overview:
- EX4 writeback buffer for the FALU fadd pipe; sits directly downstream of the FALU pipedown control.
- Captures the EX3 fadd result, fflags and destination whenever the EX3 stage pipes down with a real instruction.
- Holds captured results in a small in-order FIFO and presents them to the VPU writeback port with a valid/ready handshake.
- Drives the EX4 stall that throttles fadd EX3 pipedown.

Parameters:
- DATA_W, 64, result data width
- DST_W, 5, destination register index width
- DEPTH, 2, FIFO entries; legal values 2..4

Ports:
- forever_cpuclk  in  1  clock
- cpurst  in  1  reset, synchronous, active-high
- fadd_ex3_pipedown  in  1  EX3→EX4 advance strobe (includes warm-up)
- fadd_ex3_inst_vld  in  1  EX3 holds a real fadd instruction
- fadd_ex3_result  in  DATA_W  EX3 result data
- fadd_ex3_fflags  in  5  EX3 exception flags (NV,DZ,OF,UF,NX)
- fadd_ex3_dst  in  DST_W  EX3 destination index
- vpu_falu_flush  in  1  pipeline flush; discards all buffered results
- vpu_falu_wb_rdy  in  1  writeback port accepts the head entry this cycle
- falu_vpu_wb_vld  out  1  head entry valid
- falu_vpu_wb_data  out  DATA_W  head result
- falu_vpu_wb_fflags  out  5  head fflags
- falu_vpu_wb_dst  out  DST_W  head destination
- falu_ex4_stall  out  1  EX4 full; feeds the group EX4 stall input of the FALU control
- falu_ex4_empty  out  1  no buffered results, for idle/clock-gating logic

Behaviour:
- Reset: cpurst=1 at a clock edge clears rd/wr pointers and count to 0.
  - After reset: falu_vpu_wb_vld=0, falu_ex4_stall=0, falu_ex4_empty=1, wb data/fflags/dst=0.
  - Entry storage is also cleared to 0.
- push = fadd_ex3_pipedown & fadd_ex3_inst_vld & !vpu_falu_flush.
  - A warm-up pipedown without inst_vld never writes.
- pop = falu_vpu_wb_vld & vpu_falu_wb_rdy & !vpu_falu_flush.
- Push latency: an entry pushed at edge N is visible on the wb outputs in cycle N+1 if the FIFO was empty; no combinational input-to-output path.
- Outputs are driven from the head entry: wb_vld = (count != 0); data/fflags/dst = entry[rd_ptr]. When empty they hold the last value; the bench does not check them.
- falu_ex4_stall = (count == DEPTH).
  - Purely registered-state based; no combinational dependency on wb_rdy.
  - Full with rdy=1 still stalls that cycle. Throughput is one result per cycle while count < DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance. Allowed at any count, including 1 and DEPTH-1.
- Push while full is a protocol violation, since pipedown is gated by the stall. Assertion fires; the write is dropped and count saturates.
- Pop while empty cannot occur because wb_vld=0.
- Pointers wrap modulo DEPTH; for non-power-of-2 DEPTH, wrap explicitly at DEPTH-1 → 0.
- Flush: synchronous; clears pointers and count at the next edge.
  - Takes priority over same-cycle push and pop; both are discarded.
  - wb_vld=0 from the following cycle.
- Reset mid-transfer: reset overrides flush, push and pop; buffered results are lost.
- Storage registers are written only on push, so they may be clocked by a gated clock enabled on push|flush|cpurst.

Decomposition:
- Package aq_falu_pkg:
  - FALU_FFLAGS_W = 5
  - FALU_DATA_W default
  - typedef falu_wb_entry_t {data, fflags, dst}
- One natural sub-module, aq_falu_wb_fifo: generic synchronous FIFO with pointers, count, full and empty.
- The top level adds push/pop qualification, flush priority and stall/empty generation.

Test Plan:
- Reset then single push (result=0x3FF0_0000_0000_0000, fflags=0x01, dst=3) with rdy=1 → wb_vld=1 the next cycle with the same values; popped; empty=1 one cycle later.
- rdy=0, push 2 results (dst=1, dst=2) → count=2, stall=1, a third pipedown is withheld; rdy=1 → dst=1 then dst=2 in order, stall drops after the first pop.
- Continuous push/pop with rdy=1 for 10 results (dst 0..9) → one writeback per cycle, in order, stall never asserts; pointer wraps verified.
- Warm-up pipedown with fadd_ex3_inst_vld=0 → no entry; wb_vld stays 0.
- Count=2 with flush and push in the same cycle → count=0, wb_vld=0 next cycle; the pushed result is never written back.
- Reset asserted with count=1 and rdy=0 → all outputs return to reset values next cycle; a subsequent push behaves as the first scenario.
